// File: rtl/scoreboard_pkg.sv
// Shared encodings and default sizes for the register-read scoreboard stage.
// Multi-port buses in this block carry port 0 in their most significant slice.
package scoreboard_pkg;

    localparam logic [1:0] USE_IMM   = 2'd0;
    localparam logic [1:0] USE_READ  = 2'd1;
    localparam logic [1:0] USE_WRITE = 2'd2;
    localparam logic [1:0] USE_RW    = 2'd3;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_RD_PORTS  = 3;
    localparam int DEF_WB_PORTS  = 2;
    localparam int DEF_BYPASS    = 1;
    localparam int DEF_PAYLOAD_W = 85;

    function automatic logic use_reads(input logic [1:0] u);
        return (u == USE_READ) || (u == USE_RW);
    endfunction

    function automatic logic use_writes(input logic [1:0] u);
        return (u == USE_WRITE) || (u == USE_RW);
    endfunction

endpackage

// File: rtl/sb_read_port.sv
// Purpose: one operand port's hazard check, writeback bypass select and r0 zeroing.
// Latency: purely combinational.
// Backpressure: raises hazard flags only; the top turns them into the decode stall.
module sb_read_port
    import scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WB_PORTS = DEF_WB_PORTS,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                       i_enable,
    input  logic [1:0]                 i_use,
    input  logic                       i_zero_if_r0,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_rf_data,
    input  logic                       i_pending,
    input  logic [WB_PORTS*DATA_W-1:0] i_wb_data,
    input  logic [WB_PORTS*ADDR_W-1:0] i_wb_addr,
    input  logic [WB_PORTS-1:0]        i_wb_valid,
    output logic                       o_rd_hazard,
    output logic                       o_wr_hazard,
    output logic [DATA_W-1:0]          o_data
);
    localparam logic BYP_EN = (BYPASS != 0);

    logic              w_zero;
    logic              w_wb_hit;
    logic              w_bypass;
    logic [DATA_W-1:0] w_wb_data;

    // Ascending scan so the highest-index matching writeback wins.
    always_comb begin
        w_wb_hit  = 1'b0;
        w_wb_data = '0;
        for (int w = 0; w < WB_PORTS; w++) begin
            if (i_wb_valid[WB_PORTS-1-w] &&
                (i_wb_addr[(WB_PORTS-1-w)*ADDR_W +: ADDR_W] == i_addr)) begin
                w_wb_hit  = 1'b1;
                w_wb_data = i_wb_data[(WB_PORTS-1-w)*DATA_W +: DATA_W];
            end
        end
    end

    assign w_zero   = i_zero_if_r0 && (i_addr == '0);
    assign w_bypass = BYP_EN && w_wb_hit;

    assign o_rd_hazard = i_enable & use_reads(i_use)  & ~w_zero & i_pending & ~w_bypass;
    assign o_wr_hazard = i_enable & use_writes(i_use) & ~w_zero & i_pending & ~w_wb_hit;

    always_comb begin
        o_data = i_rf_data;
        if (!i_enable || w_zero) begin
            o_data = '0;
        end else if (w_bypass) begin
            o_data = w_wb_data;
        end
    end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Purpose: register-read stage with per-register pending scoreboard between decode and issue.
// Latency: one cycle from accept to issue outputs; writebacks land on the next edge.
// Backpressure: stall_o is combinational; decode holds its inputs while it is high.
module scoreboard_reg_file
    import scoreboard_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RD_PORTS  = DEF_RD_PORTS,
    parameter int WB_PORTS  = DEF_WB_PORTS,
    parameter int BYPASS    = DEF_BYPASS,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       enable_i,
    input  logic [RD_PORTS*ADDR_W-1:0] regAddr_i,
    input  logic [RD_PORTS-1:0]        regEnable_i,
    input  logic [RD_PORTS*2-1:0]      regUse_i,
    input  logic [RD_PORTS-1:0]        zeroIfR0_i,
    input  logic [PAYLOAD_W-1:0]       payload_i,
    input  logic [WB_PORTS*DATA_W-1:0] wbData_i,
    input  logic [WB_PORTS*ADDR_W-1:0] wbAddr_i,
    input  logic [WB_PORTS-1:0]        wbValid_i,
    output logic                       stall_o,
    output logic                       enable_o,
    output logic [RD_PORTS*DATA_W-1:0] operand_o,
    output logic [RD_PORTS-1:0]        operandEnable_o,
    output logic [RD_PORTS-1:0]        operandWriteback_o,
    output logic [RD_PORTS*ADDR_W-1:0] regAddr_o,
    output logic [PAYLOAD_W-1:0]       payload_o
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]          r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]        r_pending;
    logic                       r_enable;
    logic [RD_PORTS*DATA_W-1:0] r_operand;
    logic [RD_PORTS-1:0]        r_op_enable;
    logic [RD_PORTS-1:0]        r_op_wb;
    logic [RD_PORTS*ADDR_W-1:0] r_addr;
    logic [PAYLOAD_W-1:0]       r_payload;

    logic [RD_PORTS-1:0]        w_rd_hazard;
    logic [RD_PORTS-1:0]        w_wr_hazard;
    logic [RD_PORTS-1:0]        w_is_dest;
    logic [DATA_W-1:0]          w_port_data [RD_PORTS];
    logic [RD_PORTS*DATA_W-1:0] w_operand;
    logic [NUM_REGS-1:0]        w_pending_nxt;
    logic                       w_stall;
    logic                       w_accept;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        localparam int S = RD_PORTS - 1 - p;
        logic [ADDR_W-1:0] w_addr;
        logic [1:0]        w_use;

        assign w_addr       = regAddr_i[S*ADDR_W +: ADDR_W];
        assign w_use        = regUse_i[S*2 +: 2];
        assign w_is_dest[S] = regEnable_i[S] & use_writes(w_use);

        sb_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .WB_PORTS(WB_PORTS),
            .BYPASS  (BYPASS)
        ) u_port (
            .i_enable    (regEnable_i[S]),
            .i_use       (w_use),
            .i_zero_if_r0(zeroIfR0_i[S]),
            .i_addr      (w_addr),
            .i_rf_data   (r_regs[w_addr]),
            .i_pending   (r_pending[w_addr]),
            .i_wb_data   (wbData_i),
            .i_wb_addr   (wbAddr_i),
            .i_wb_valid  (wbValid_i),
            .o_rd_hazard (w_rd_hazard[S]),
            .o_wr_hazard (w_wr_hazard[S]),
            .o_data      (w_port_data[S])
        );
    end

    always_comb begin
        w_operand = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            w_operand[p*DATA_W +: DATA_W] = w_port_data[p];
        end
    end

    assign w_stall  = enable_i & (|(w_rd_hazard | w_wr_hazard));
    assign w_accept = enable_i & ~w_stall;
    assign stall_o  = w_stall;

    // Clears applied before sets so a new destination stays pending.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int w = 0; w < WB_PORTS; w++) begin
            if (wbValid_i[WB_PORTS-1-w]) begin
                w_pending_nxt[wbAddr_i[(WB_PORTS-1-w)*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (w_accept) begin
            for (int p = 0; p < RD_PORTS; p++) begin
                if (w_is_dest[p]) begin
                    w_pending_nxt[regAddr_i[p*ADDR_W +: ADDR_W]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending   <= '0;
            r_enable    <= 1'b0;
            r_operand   <= '0;
            r_op_enable <= '0;
            r_op_wb     <= '0;
            r_addr      <= '0;
            r_payload   <= '0;
        end else begin
            for (int w = 0; w < WB_PORTS; w++) begin
                if (wbValid_i[WB_PORTS-1-w]) begin
                    r_regs[wbAddr_i[(WB_PORTS-1-w)*ADDR_W +: ADDR_W]] <=
                        wbData_i[(WB_PORTS-1-w)*DATA_W +: DATA_W];
                end
            end
            r_pending   <= w_pending_nxt;
            r_enable    <= w_accept;
            r_operand   <= w_accept ? w_operand   : '0;
            r_op_enable <= w_accept ? regEnable_i : '0;
            r_op_wb     <= w_accept ? w_is_dest   : '0;
            r_addr      <= w_accept ? regAddr_i   : '0;
            r_payload   <= w_accept ? payload_i   : '0;
        end
    end

    assign enable_o           = r_enable;
    assign operand_o          = r_operand;
    assign operandEnable_o    = r_op_enable;
    assign operandWriteback_o = r_op_wb;
    assign regAddr_o          = r_addr;
    assign payload_o          = r_payload;

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Bench for scoreboard_reg_file: one bypassing and one non-bypassing instance on shared stimulus.
// Expected issue records are queued at accept time and retired when enable_o rises.
module tb_scoreboard_reg_file;
    import scoreboard_pkg::*;

    localparam int DW = 64, AW = 5, RP = 3, WP = 2, PW = 85;

    logic              clock_i;
    logic              reset_i;
    logic              enable_i;
    logic [RP*AW-1:0]  regAddr_i;
    logic [RP-1:0]     regEnable_i;
    logic [RP*2-1:0]   regUse_i;
    logic [RP-1:0]     zeroIfR0_i;
    logic [PW-1:0]     payload_i;
    logic [WP*DW-1:0]  wbData_i;
    logic [WP*AW-1:0]  wbAddr_i;
    logic [WP-1:0]     wbValid_i;

    logic              b_stall, b_en, n_stall, n_en;
    logic [RP*DW-1:0]  b_op, n_op;
    logic [RP-1:0]     b_ope, n_ope, b_opw, n_opw;
    logic [RP*AW-1:0]  b_addr, n_addr;
    logic [PW-1:0]     b_pay, n_pay;

    logic              dsel;
    logic              s_stall, s_en;
    logic [RP*DW-1:0]  s_op;
    logic [RP-1:0]     s_ope, s_opw;
    logic [RP*AW-1:0]  s_addr;
    logic [PW-1:0]     s_pay;

    int                n_cmp, n_err;
    logic [31:0]       pay_cnt;

    typedef struct {
        logic [RP*DW-1:0] ops;
        logic [RP-1:0]    rmask;
        logic [RP*AW-1:0] addr;
        logic [RP-1:0]    enb;
        logic [RP-1:0]    wbk;
        logic [PW-1:0]    pay;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0][AW-1:0] a;
        logic [2:0]         zr;
        logic [2:0][DW-1:0] e;
    } rv_t;
    rv_t tbl[5];

    scoreboard_reg_file #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .WB_PORTS(WP),
                          .BYPASS(1), .PAYLOAD_W(PW)) u_dut_byp (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .regAddr_i(regAddr_i), .regEnable_i(regEnable_i), .regUse_i(regUse_i),
        .zeroIfR0_i(zeroIfR0_i), .payload_i(payload_i), .wbData_i(wbData_i),
        .wbAddr_i(wbAddr_i), .wbValid_i(wbValid_i), .stall_o(b_stall),
        .enable_o(b_en), .operand_o(b_op), .operandEnable_o(b_ope),
        .operandWriteback_o(b_opw), .regAddr_o(b_addr), .payload_o(b_pay));

    scoreboard_reg_file #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .WB_PORTS(WP),
                          .BYPASS(0), .PAYLOAD_W(PW)) u_dut_nobyp (
        .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
        .regAddr_i(regAddr_i), .regEnable_i(regEnable_i), .regUse_i(regUse_i),
        .zeroIfR0_i(zeroIfR0_i), .payload_i(payload_i), .wbData_i(wbData_i),
        .wbAddr_i(wbAddr_i), .wbValid_i(wbValid_i), .stall_o(n_stall),
        .enable_o(n_en), .operand_o(n_op), .operandEnable_o(n_ope),
        .operandWriteback_o(n_opw), .regAddr_o(n_addr), .payload_o(n_pay));

    assign s_stall = dsel ? n_stall : b_stall;
    assign s_en    = dsel ? n_en    : b_en;
    assign s_op    = dsel ? n_op    : b_op;
    assign s_ope   = dsel ? n_ope   : b_ope;
    assign s_opw   = dsel ? n_opw   : b_opw;
    assign s_addr  = dsel ? n_addr  : b_addr;
    assign s_pay   = dsel ? n_pay   : b_pay;

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [RP*DW-1:0] act, input logic [RP*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic set_pay();
        payload_i = {21'h15A5A, pay_cnt, 32'hC0DE_0000 ^ pay_cnt};
    endtask

    task automatic clr_in();
        enable_i = 1'b0; regAddr_i = '0; regEnable_i = '0; regUse_i = '0;
        zeroIfR0_i = '0; wbData_i = '0; wbAddr_i = '0; wbValid_i = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a, input logic [1:0] u, input logic zr);
        enable_i = 1'b1;
        regEnable_i[RP-1-p] = 1'b1;
        regAddr_i[(RP-1-p)*AW +: AW] = a;
        regUse_i[(RP-1-p)*2 +: 2] = u;
        zeroIfR0_i[RP-1-p] = zr;
    endtask

    task automatic set_wb(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wbValid_i[WP-1-w] = 1'b1;
        wbAddr_i[(WP-1-w)*AW +: AW] = a;
        wbData_i[(WP-1-w)*DW +: DW] = d;
    endtask

    // One decode cycle: inputs already driven; check stall, queue expectation, retire at negedge.
    task automatic cycle(input logic xs, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2);
        exp_t r, got;
        logic acc;
        logic [1:0] u;
        logic [DW-1:0] ep [RP];
        ep[0] = e0; ep[1] = e1; ep[2] = e2;
        #1;
        chk("stall_o", s_stall, xs);
        acc = enable_i & ~xs;
        if (acc) begin
            r.ops = '0;
            for (int p = 0; p < RP; p++) begin
                u = regUse_i[(RP-1-p)*2 +: 2];
                r.ops[(RP-1-p)*DW +: DW] = ep[p];
                r.rmask[p] = regEnable_i[RP-1-p] & ((u == USE_READ) || (u == USE_RW));
                r.wbk[RP-1-p] = regEnable_i[RP-1-p] & ((u == USE_WRITE) || (u == USE_RW));
            end
            r.addr = regAddr_i;
            r.enb  = regEnable_i;
            r.pay  = payload_i;
            sbq.push_back(r);
        end
        @(posedge clock_i);
        @(negedge clock_i);
        chk("enable_o", s_en, acc);
        if (s_en) begin
            chk("scoreboard has entry", sbq.size() > 0, 1'b1);
            if (sbq.size() > 0) begin
                got = sbq.pop_front();
                for (int p = 0; p < RP; p++)
                    if (got.rmask[p]) chk($sformatf("operand%0d", p),
                                          s_op[(RP-1-p)*DW +: DW], got.ops[(RP-1-p)*DW +: DW]);
                chk("regAddr_o", s_addr, got.addr);
                chk("operandEnable_o", s_ope, got.enb);
                chk("operandWriteback_o", s_opw, got.wbk);
                chk("payload_o", s_pay, got.pay);
            end
        end else begin
            chk("idle operand_o", s_op, '0);
            chk("idle payload_o", s_pay, '0);
        end
        clr_in();
        pay_cnt++;
        set_pay();
    endtask

    task automatic do_reset();
        clr_in();
        reset_i = 1'b1;
        @(posedge clock_i);
        @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " enable_o"}, s_en, '0);
        chk({tag, " operand_o"}, s_op, '0);
        chk({tag, " payload_o"}, s_pay, '0);
        chk({tag, " regAddr_o"}, s_addr, '0);
        chk({tag, " operandEnable_o"}, s_ope, '0);
        chk({tag, " operandWriteback_o"}, s_opw, '0);
    endtask

    function automatic rv_t mkrv(input logic [AW-1:0] a0, a1, a2, input logic [2:0] zr,
                                 input logic [DW-1:0] e0, e1, e2);
        rv_t v;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.zr = zr;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
        return v;
    endfunction

    initial begin
        n_cmp = 0; n_err = 0; pay_cnt = 0; dsel = 1'b0;
        reset_i = 1'b1;
        clr_in();
        set_pay();

        // zr bit p applies to port p
        tbl[0] = mkrv(5, 1, 4,  3'b000, 10, 7, 22);
        tbl[1] = mkrv(3, 2, 0,  3'b100, 44, 5, 0);
        tbl[2] = mkrv(4, 4, 5,  3'b000, 22, 22, 10);
        tbl[3] = mkrv(31, 1, 3, 3'b000, 0, 7, 44);
        tbl[4] = mkrv(0, 0, 1,  3'b010, 9, 0, 7);

        do_reset();
        chk_all_zero("reset byp");
        chk("reset stall byp", b_stall, 1'b0);
        dsel = 1'b1;
        chk_all_zero("reset nobyp");
        dsel = 1'b0;

        set_wb(0, 5, 10); set_wb(1, 1, 7);                       cycle(0, 0, 0, 0);
        set_rd(0, 5, USE_READ, 0); set_rd(1, 1, USE_READ, 0);
        set_rd(2, 0, USE_READ, 1);                               cycle(0, 10, 7, 0);

        set_rd(0, 2, USE_WRITE, 0);                              cycle(0, 0, 0, 0);
        set_rd(0, 2, USE_READ, 0);                               cycle(1, 0, 0, 0);
        set_rd(0, 2, USE_READ, 0);                               cycle(1, 0, 0, 0);
        set_rd(0, 2, USE_READ, 0); set_wb(0, 2, 5);              cycle(0, 5, 0, 0);
        set_rd(0, 2, USE_READ, 0);                               cycle(0, 5, 0, 0);

        set_rd(1, 3, USE_WRITE, 0);                              cycle(0, 0, 0, 0);
        set_rd(1, 3, USE_WRITE, 0);                              cycle(1, 0, 0, 0);
        set_rd(1, 3, USE_WRITE, 0); set_wb(1, 3, 33);            cycle(0, 0, 0, 0);
        set_rd(0, 3, USE_READ, 0);                               cycle(1, 0, 0, 0);
        set_wb(0, 3, 44); set_wb(1, 0, 9);                       cycle(0, 0, 0, 0);
        set_wb(0, 4, 11); set_wb(1, 4, 22);                      cycle(0, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            for (int p = 0; p < RP; p++) set_rd(p, tbl[i].a[p], USE_READ, tbl[i].zr[p]);
            cycle(0, tbl[i].e[0], tbl[i].e[1], tbl[i].e[2]);
        end

        set_rd(0, 5, USE_RW, 0);                                 cycle(0, 10, 0, 0);
        set_rd(0, 5, USE_READ, 0);                               cycle(1, 0, 0, 0);
        set_rd(2, 0, USE_WRITE, 0);                              cycle(0, 0, 0, 0);
        set_rd(0, 0, USE_READ, 1); set_rd(1, 0, USE_RW, 1);      cycle(0, 0, 0, 0);
        set_rd(0, 0, USE_READ, 0);                               cycle(1, 0, 0, 0);
        set_rd(0, 1, USE_READ, 0); set_wb(0, 1, 77);             cycle(0, 77, 0, 0);

        // Reset with a pending register and a live instruction plus writeback.
        set_rd(0, 6, USE_WRITE, 0);                              cycle(0, 0, 0, 0);
        reset_i = 1'b1;
        set_rd(0, 6, USE_READ, 0); set_wb(0, 7, 99);
        @(posedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        clr_in();
        chk_all_zero("mid reset");
        set_rd(0, 6, USE_READ, 0); set_rd(1, 7, USE_READ, 0);
        set_rd(2, 5, USE_READ, 0);                               cycle(0, 0, 0, 0);

        dsel = 1'b1;
        do_reset();
        set_rd(0, 2, USE_WRITE, 0);                              cycle(0, 0, 0, 0);
        set_rd(0, 2, USE_READ, 0);                               cycle(1, 0, 0, 0);
        set_rd(0, 2, USE_READ, 0); set_wb(0, 2, 5);              cycle(1, 0, 0, 0);
        set_rd(0, 2, USE_READ, 0);                               cycle(0, 5, 0, 0);
        set_rd(0, 2, USE_READ, 0); set_wb(1, 2, 6);              cycle(0, 5, 0, 0);
        set_rd(0, 2, USE_READ, 0);                               cycle(0, 6, 0, 0);

        chk("scoreboard drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scoreboard_reg_file.md
# scoreboard_reg_file

Parametrised register-read stage with per-register scoreboard: N read/issue ports, M writeback ports, optional writeback-to-read bypass, and WAW hazard detection. It sits between decode and the execution units, succeeding the fixed 3-read/2-writeback register unit. It reads operands, marks destination registers pending, stalls decode on RAW/WAW hazards, and forwards decode payload to issue with one cycle of latency.

## Interface
- DATA_W, 64, register width
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- RD_PORTS, 3, operand ports per instruction
- WB_PORTS, 2, writeback ports
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read; 0 = such reads stall
- PAYLOAD_W, 85, opaque decode fields (address, opcode, xOpcode, format, imm, bits), passed through
- clock_i  in  1  clock; one clock; all state on rising edge
- reset_i  in  1  reset is synchronous and active-high
- enable_i  in  1  instruction valid from decode
- regAddr_i  in  RD_PORTS*ADDR_W  operand register addresses, port 0 in MSBs
- regEnable_i  in  RD_PORTS  port in use
- regUse_i  in  RD_PORTS*2  0 imm, 1 read, 2 write, 3 read/write
- zeroIfR0_i  in  RD_PORTS  address 0 reads as literal zero
- payload_i  in  PAYLOAD_W  passthrough
- wbData_i  in  WB_PORTS*DATA_W  writeback data
- wbAddr_i  in  WB_PORTS*ADDR_W  writeback addresses
- wbValid_i  in  WB_PORTS  writeback strobes
- stall_o  out  1  combinational; decode must hold inputs
- enable_o  out  1  registered issue valid
- operand_o  out  RD_PORTS*DATA_W  operand values
- operandEnable_o  out  RD_PORTS  registered regEnable_i
- operandWriteback_o  out  RD_PORTS  port is a destination (use 2 or 3)
- regAddr_o  out  RD_PORTS*ADDR_W  registered addresses
- payload_o  out  PAYLOAD_W  registered payload

## Operation
- Reset: register file all zero, every pending bit clear, every output zero.
- Writeback: each cycle, every wbValid_i port writes its register and clears its pending bit. If two ports hit the same address, the highest-index port wins.
- Read hazard: an enabled port with use 1/3 whose register is pending.
  - Cleared when a same-cycle writeback targets that register and BYPASS=1; data then comes from that writeback, highest-index port winning.
  - With BYPASS=0 the hazard stands.
- Write hazard (WAW): an enabled port with use 2/3 whose register is pending and not cleared by a same-cycle writeback (regardless of BYPASS).
- zeroIfR0_i with address 0: operand is 0 and the port raises no hazard.
- Use 0 (imm) ports never raise a hazard.
- stall_o = enable_i & (any read or write hazard).
- Accept = enable_i & ~stall_o. On accept:
  - outputs load next edge, enable_o=1;
  - pending bits set for all write-use ports.
- Pending set and clear on the same register in the same cycle: set wins.
- No accept: enable_o=0 next edge; operand_o, payload_o, and the remaining outputs are forced to zero.
- An instruction whose read and write use the same pending-free register reads the pre-write value.

## Timing
- Read latency 1 cycle: operands appear the edge after accept.
- Writeback visible to a non-bypassed read the cycle after wbValid_i.
- Bypass is combinational from wbData_i to the operand register, so wbData_i is on the critical path.
- stall_o depends combinationally on enable_i, addresses, wbValid_i and wbAddr_i. Decode must not feed stall_o back into enable_i.
- Reset mid-operation: pending bits and outputs clear on that edge. Writebacks in the reset cycle are discarded.

## Structure
- Package scoreboard_pkg: regUse encoding constants (USE_IMM=0, USE_READ=1, USE_WRITE=2, USE_RW=3) and default parameter values.
- Sub-module sb_read_port: one read port's hazard check, bypass select and zero handling, instantiated RD_PORTS times.
- Register file array and pending vector stay in the top module.

## Test plan
- Reset, then writeback r5=10 and r1=7; next cycle read r5,r1 (use 1) -> enable_o=1, operands 10 and 7, stall_o=0.
- Issue with r2 use 2; next cycle read r2 -> stall_o=1 and enable_o=0 each cycle. Then writeback r2=5 with BYPASS=1 -> stall_o=0 that cycle, operand 5 next cycle.
- Same sequence with BYPASS=0 -> stall persists during the writeback cycle, and the read succeeds one cycle later with value 5.
- r3 pending, issue write to r3 -> WAW stall_o=1. Writeback r3 and issue a new write in the same cycle -> accepted, and r3 is pending again afterwards.
- Both wb ports write r4 (11 on port 0, 22 on port 1) -> subsequent read returns 22. Read r0 with zeroIfR0=1 after writing r0=9 -> 0, and no stall while r0 is pending.
- Assert reset while r6 is pending and enable_i=1 -> all outputs 0 next edge, and a later read of r6 returns 0 with no stall.
